// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions: FSM states, parity modes, oversample factor.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  localparam int OS_TICK = 16;

  // Data is zero-extended to 9 bits, which leaves the XOR of the word unchanged.
  function automatic logic parity_bit(input logic [8:0] data, input int mode);
    parity_bit = (mode == PAR_ODD) ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: start, DBIT data bits LSB first, optional parity, stop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int PARITY  = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            s_tick,
  input  logic            tx_start,
  input  logic [DBIT-1:0] tx_din,
  output logic            tx_busy,
  output logic            tx_done_tick,
  output logic            tx
);

  localparam int              NW        = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [4:0]      S_LAST    = 5'(OS_TICK - 1);
  localparam logic [4:0]      STOP_LAST = 5'(SB_TICK - 1);
  localparam logic [NW-1:0]   N_LAST    = NW'(DBIT - 1);

  uart_state_e     state_q, state_d;
  logic [4:0]      s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] shift_q, shift_d;
  logic            par_q, par_d;
  logic            tx_q, tx_d;
  logic            busy_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    n_d          = n_q;
    shift_d      = shift_q;
    par_d        = par_q;
    tx_d         = 1'b1;
    tx_done_tick = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tx_start) begin
          shift_d = tx_din;
          // Parity is fixed at acceptance; the shift register is consumed during the frame.
          par_d   = parity_bit(9'(tx_din), PARITY);
          s_d     = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        tx_d = 1'b0;
        if (s_tick) begin
          if (s_q == S_LAST) begin
            s_d     = '0;
            n_d     = '0;
            state_d = ST_DATA;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      ST_DATA: begin
        tx_d = shift_q[0];
        if (s_tick) begin
          if (s_q == S_LAST) begin
            s_d     = '0;
            shift_d = shift_q >> 1;
            if (n_q == N_LAST) begin
              state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      ST_PARITY: begin
        tx_d = par_q;
        if (s_tick) begin
          if (s_q == S_LAST) begin
            s_d     = '0;
            state_d = ST_STOP;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      ST_STOP: begin
        tx_d = 1'b1;
        if (s_tick) begin
          if (s_q == STOP_LAST) begin
            tx_done_tick = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed bench for uart_tx with a behavioural receiver for loopback.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       tick_en;
  int         tick_div;
  int         tcnt = 0;
  logic       s_tick;
  logic [3:0] start_v;
  logic [7:0] din;
  logic [3:0] tx_w, busy_w, done_w;
  logic [1:0] sel;
  logic       tx_sel, busy_sel, done_sel;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tcnt >= tick_div - 1) tcnt <= 0;
    else                      tcnt <= tcnt + 1;
  end
  assign s_tick = tick_en && (tcnt == 0);

  assign tx_sel   = tx_w[sel];
  assign busy_sel = busy_w[sel];
  assign done_sel = done_w[sel];

  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY(0)) u_none (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .tx_start(start_v[0]), .tx_din(din),
    .tx_busy(busy_w[0]), .tx_done_tick(done_w[0]), .tx(tx_w[0]));
  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY(2)) u_even (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .tx_start(start_v[1]), .tx_din(din),
    .tx_busy(busy_w[1]), .tx_done_tick(done_w[1]), .tx(tx_w[1]));
  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY(1)) u_odd (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .tx_start(start_v[2]), .tx_din(din),
    .tx_busy(busy_w[2]), .tx_done_tick(done_w[2]), .tx(tx_w[2]));
  uart_tx #(.DBIT(8), .SB_TICK(32), .PARITY(0)) u_sb32 (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .tx_start(start_v[3]), .tx_din(din),
    .tx_busy(busy_w[3]), .tx_done_tick(done_w[3]), .tx(tx_w[3]));

  // Behavioural 16x receiver on u_none's line: mid-start check, then centre sampling.
  logic       rx_en = 1'b0;
  int         rx_st = 0, rx_s = 0, rx_n = 0, done5 = 0;
  logic [7:0] rx_sh = 8'h00;
  logic [7:0] rx_q[$];

  always @(negedge clk) begin
    if (!rx_en) begin
      rx_st = 0;
    end else begin
      if (done_w[0]) done5++;
      if (s_tick) begin
        case (rx_st)
          0: if (tx_w[0] == 1'b0) begin rx_st = 1; rx_s = 0; end
          1: if (rx_s == 7) begin
               if (tx_w[0] == 1'b0) begin rx_st = 2; rx_s = 0; rx_n = 0; end
               else rx_st = 0;
             end else rx_s++;
          2: if (rx_s == 15) begin
               rx_s  = 0;
               rx_sh = {tx_w[0], rx_sh[7:1]};
               if (rx_n == 7) rx_st = 3; else rx_n++;
             end else rx_s++;
          default: if (rx_s == 15) begin rx_q.push_back(rx_sh); rx_st = 0; end
                   else rx_s++;
        endcase
      end
    end
  end

  logic lv [0:255];
  int   tk, done_cnt, done_at;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [1:0] s, input logic [7:0] d);
    sel = s;
    @(negedge clk);
    din        = d;
    start_v[s] = 1'b1;
    @(negedge clk);
    start_v[s] = 1'b0;
  endtask

  // Records the tx level belonging to each s_tick (sampled one clk later, after tx_q settles).
  task automatic capture(input int total, input int inject_at, input int pause_at,
                         input logic pause_lvl, input int abort_at);
    int   cyc;
    logic prev, fin, inj_clr;
    tk = 0; done_cnt = 0; done_at = -1;
    prev = 1'b0; fin = 1'b0; inj_clr = 1'b0; cyc = 0;
    while (!fin && cyc < 4000) begin
      if (inj_clr) begin start_v[sel] = 1'b0; inj_clr = 1'b0; end
      if (prev) begin
        lv[tk-1] = tx_sel;
        if (tk == 1) chk("busy_in_frame", 32'(busy_sel), 32'd1);
        if (tk == inject_at) begin start_v[sel] = 1'b1; din = 8'hFF; inj_clr = 1'b1; end
        if (tk == pause_at) begin
          tick_en = 1'b0;
          repeat (100) @(negedge clk);
          chk("pause_hold", 32'(tx_sel), 32'(pause_lvl));
          tick_en = 1'b1;
        end
        if (tk == abort_at) begin
          reset_n = 1'b0;
          #1;
          chk("abort_tx_high", 32'(tx_sel), 32'd1);
          chk("abort_busy_low", 32'(busy_sel), 32'd0);
          fin = 1'b1;
        end
        if (tk == total) begin
          chk("busy_after_done", 32'(busy_sel), 32'd0);
          fin = 1'b1;
        end
      end
      if (!fin && s_tick) begin
        tk++;
        if (done_sel) begin done_cnt++; done_at = tk; end
      end
      prev = s_tick && !fin;
      if (!fin) begin @(negedge clk); cyc++; end
    end
    if (!fin) chk("capture_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_frame(input string tag, input logic [7:0] d, input int par, input int sb);
    logic ex  [0:10];
    int   len [0:10];
    int   ns, base;
    logic stable;
    ns = 0;
    ex[ns] = 1'b0; len[ns] = 16; ns++;
    for (int b = 0; b < 8; b++) begin ex[ns] = d[b]; len[ns] = 16; ns++; end
    if (par != 0) begin ex[ns] = (par == 2) ? ^d : ~^d; len[ns] = 16; ns++; end
    ex[ns] = 1'b1; len[ns] = sb; ns++;
    base = 0;
    for (int j = 0; j < ns; j++) begin
      stable = 1'b1;
      for (int k = 1; k < len[j]; k++) if (lv[base+k] !== lv[base]) stable = 1'b0;
      chk($sformatf("%s_slot%0d", tag, j), 32'({stable, lv[base]}), 32'({1'b1, ex[j]}));
      base += len[j];
    end
    chk({tag, "_done_at"}, 32'(done_at), 32'(base));
    chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
  endtask

  initial begin
    int c;
    reset_n = 1'b0; tick_en = 1'b1; tick_div = 4;
    start_v = 4'h0; din = 8'h00; sel = 2'd0;
    repeat (3) @(negedge clk);
    chk("reset_tx", 32'(tx_w), 32'hF);
    chk("reset_busy", 32'(busy_w), 32'h0);
    chk("reset_done", 32'(done_w), 32'h0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_tx", 32'(tx_w), 32'hF);
    chk("idle_busy", 32'(busy_w), 32'h0);

    send(2'd0, 8'h55); capture(160, -1, -1, 1'b0, -1);
    check_frame("t1_55", 8'h55, 0, 16);
    chk("t1_line_idle", 32'(tx_w[0]), 32'd1);

    send(2'd1, 8'h07); capture(176, -1, -1, 1'b0, -1);
    check_frame("t2_even", 8'h07, 2, 16);
    chk("t2_even_bit", 32'(lv[144]), 32'd1);
    send(2'd2, 8'h07); capture(176, -1, -1, 1'b0, -1);
    check_frame("t2_odd", 8'h07, 1, 16);
    chk("t2_odd_bit", 32'(lv[144]), 32'd0);

    send(2'd0, 8'h3C); capture(160, 40, -1, 1'b0, -1);
    check_frame("t3_3c", 8'h3C, 0, 16);
    repeat (200) @(negedge clk);
    chk("t3_no_second_frame", 32'(busy_w[0]), 32'd0);
    chk("t3_line_idle", 32'(tx_w[0]), 32'd1);

    send(2'd0, 8'hC3); capture(160, -1, -1, 1'b0, 50);
    chk("t4_no_done", 32'(done_cnt), 32'd0);
    @(negedge clk); reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t4_idle_after_reset", 32'(tx_w[0]), 32'd1);
    send(2'd0, 8'hA5); capture(160, -1, -1, 1'b0, -1);
    check_frame("t4_a5", 8'hA5, 0, 16);

    send(2'd3, 8'h55); capture(192, -1, 70, 1'b0, -1);
    check_frame("t6_sb32", 8'h55, 0, 32);

    @(negedge clk);
    tick_div = 1; rx_q.delete(); rx_en = 1'b1; sel = 2'd0;
    din = 8'h00; start_v[0] = 1'b1;
    for (int i = 0; i < 256; i++) begin
      c = 0;
      while (busy_w[0] !== 1'b1 && c < 20) begin @(negedge clk); c++; end
      if (c >= 20) chk("t5_accept_timeout", 32'd0, 32'd1);
      if (i == 255) start_v[0] = 1'b0; else din = 8'(i + 1);
      c = 0;
      while (busy_w[0] !== 1'b0 && c < 400) begin @(negedge clk); c++; end
      if (c >= 400) chk("t5_frame_timeout", 32'd0, 32'd1);
    end
    repeat (5) @(negedge clk);
    chk("t5_rx_count", 32'(rx_q.size()), 32'd256);
    chk("t5_done_count", 32'(done5), 32'd256);
    for (int i = 0; i < 256; i++)
      if (i < rx_q.size()) chk($sformatf("t5_word%0d", i), 32'(rx_q[i]), 32'(i));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
